ecc_sram_secded: RTL

- Parametrised single-port memory with SECDED Hamming protection.
- Successor to the fixed 4-bit Hamming(7,4) encode/decode pair: generic data width, an extra overall-parity bit for double-error detection, a registered 2-cycle read pipeline, a valid/ready request handshake, a power-up zero-initialisation sweep, optional corrected-data writeback (scrub) and saturating error counters.
- Sits between a bus-side requester and an on-chip array inside the memory subsystem.

---
 rtl/ecc_sram_secded.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ecc_sram_secded.sv
// SECDED-protected single-port word memory: zero-init sweep, 2-cycle read pipeline, optional scrub writeback.
// Optional error injection on host writes is enabled with `define ECC_ERR_INJ_EN.
module ecc_sram_secded #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int SCRUB_WB = 1,
  parameter int CNT_W    = 16,
  localparam int P       = $clog2(DATA_W + 1 + $clog2(DATA_W + 1)),
  localparam int CODE_W  = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ECC_ERR_INJ_EN
  input  logic [CODE_W-1:0] inj_mask,
  output logic              inj_active,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_sec,
  output logic              rsp_ded,
  output logic              init_done,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count
);

  localparam int N     = DATA_W + P;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_SCRUB} state_t;

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int k;
    c = '0;
    k = 0;
    for (int i = 1; i <= N; i++)
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    for (int p = 0; p < P; p++)
      for (int i = 1; i <= N; i++)
        if (((i >> p) & 1) != 0 && i != (1 << p)) c[1 << p] = c[1 << p] ^ c[i];
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i <= N; i++)
      if ((i & (i - 1)) != 0) begin
        d[k] = c[i];
        k++;
      end
    return d;
  endfunction

  function automatic logic [P-1:0] syndrome(input logic [CODE_W-1:0] c);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i <= N; i++)
      if (c[i]) s = s ^ P'(i);
    return s;
  endfunction

  logic [CODE_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_addr;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [CODE_W-1:0] s1_code;
  logic [ADDR_W-1:0] scrub_addr;
  logic [CODE_W-1:0] scrub_code;

  logic              host_wr, host_rd;
  logic [CODE_W-1:0] inj_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [CODE_W-1:0] mem_wdata;

  logic [P-1:0]      syn;
  logic              op, dec_sec, dec_ded, scrub_arm;
  logic [CODE_W-1:0] corrected;

  assign host_wr = req_valid && req_ready && req_we;
  assign host_rd = req_valid && req_ready && !req_we;

`ifdef ECC_ERR_INJ_EN
  assign inj_word   = inj_mask;
  assign inj_active = host_wr && (inj_mask != '0);
`else
  assign inj_word = '0;
`endif

  // Decode stage: syndrome 0 with odd parity corrects bit 0 through the same shift.
  assign syn       = syndrome(s1_code);
  assign op        = ^s1_code;
  assign dec_sec   = op && (int'(syn) <= N);
  assign dec_ded   = (op && !dec_sec) || (!op && syn != '0);
  assign corrected = s1_code ^ (CODE_W'(1) << syn);
  // A host write to the same word in the decode cycle supersedes the scrub.
  assign scrub_arm = (SCRUB_WB != 0) && s1_valid && dec_sec &&
                     !(host_wr && req_addr == s1_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_addr == '1) state_nxt = S_RUN;
      S_RUN,
      S_SCRUB: state_nxt = scrub_arm ? S_SCRUB : S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = encode(req_wdata) ^ inj_word;
    case (state)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = init_addr;
        mem_wdata = encode('0);
      end
      S_RUN: begin
        req_ready = 1'b1;
        mem_we    = host_wr;
      end
      S_SCRUB: begin
        mem_we    = 1'b1;
        mem_addr  = scrub_addr;
        mem_wdata = scrub_code;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_addr  <= '0;
      init_done  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_code    <= '0;
      scrub_addr <= '0;
      scrub_code <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_sec    <= 1'b0;
      rsp_ded    <= 1'b0;
      sec_count  <= '0;
      ded_count  <= '0;
    end else begin
      if (state == S_INIT) begin
        init_addr <= init_addr + 1'b1;
        if (init_addr == '1) init_done <= 1'b1;
      end
      s1_valid <= host_rd;
      if (host_rd) begin
        s1_addr <= req_addr;
        s1_code <= mem[req_addr];
      end
      if (scrub_arm) begin
        scrub_addr <= s1_addr;
        scrub_code <= corrected;
      end
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_rdata <= extract(dec_sec ? corrected : s1_code);
        rsp_sec   <= dec_sec;
        rsp_ded   <= dec_ded;
        if (dec_sec && sec_count != '1) sec_count <= sec_count + 1'b1;
        if (dec_ded && ded_count != '1) ded_count <= ded_count + 1'b1;
      end
    end
  end

endmodule
